// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that funnels NREQ requesters into one FIFO
//   write port. A requester holds the grant for up to BURST words. The grant
//   ends early if its req_valid drops. Each new grant costs one idle
//   arbitration cycle. Data passes through combinationally, so a word is
//   written on the same edge on which it is accepted.
//
// Parameters
//   WIDTH  data word width (bits)
//   NREQ   number of requesters, 2..8
//   BURST  maximum words per grant, 1..16
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   req_valid     per-requester word offered
//   req_data      requester k word at [k*WIDTH +: WIDTH]
//   req_ready     per-requester word accepted this cycle
//   fifo_full     downstream FIFO full
//   fifo_w_valid  FIFO write strobe
//   fifo_data_in  FIFO write data
//   grant_active  a requester holds the grant
//   grant_id      grant owner index (meaningful when grant_active=1)
//   wr_count      total words written, wraps at 16 bits
module fifo_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_w_valid,
    output logic [WIDTH-1:0]      fifo_data_in,
    output logic                  grant_active,
    output logic [2:0]            grant_id,
    output logic [15:0]           wr_count
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [4:0] BURST_LAST = 5'(BURST - 1);
    localparam logic [2:0] LAST_INIT  = 3'(NREQ - 1);

    state_t          state_reg;
    logic [2:0]      owner_reg;
    logic [2:0]      last_owner_reg;
    logic [4:0]      burst_cnt_reg;
    logic [15:0]     wr_count_reg;

    logic [NREQ-1:0] owner_sel;
    logic            owner_valid;
    logic [2:0]      pick_next;
    int              rr_dist;
    int              rr_best;

    // One-hot decode of the owner; drives the per-requester ready outputs.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign owner_sel[gi] = (owner_reg == 3'(gi));
            assign req_ready[gi] = (state_reg == GRANT) && owner_sel[gi] && !fifo_full;
        end
    endgenerate

    assign owner_valid  = |(req_valid & owner_sel);
    assign fifo_w_valid = |(req_valid & req_ready);
    assign grant_active = (state_reg == GRANT);
    assign grant_id     = owner_reg;
    assign wr_count     = wr_count_reg;

    // Owner data mux; owner_sel is one-hot, so the ordering does not matter.
    always_comb begin
        fifo_data_in = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_sel[k]) begin
                fifo_data_in = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pick: the valid requester at the smallest distance past
    // last_owner wins. last_owner resets to NREQ-1, so requester 0 is
    // searched first after reset.
    always_comb begin
        pick_next = '0;
        rr_dist   = 0;
        rr_best   = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            rr_dist = k - int'(last_owner_reg) - 1;
            if (rr_dist < 0) begin
                rr_dist = rr_dist + NREQ;
            end
            if (req_valid[k] && (rr_dist < rr_best)) begin
                rr_best   = rr_dist;
                pick_next = 3'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= LAST_INIT;
            burst_cnt_reg  <= '0;
            wr_count_reg   <= '0;
        end else begin
            if (fifo_w_valid) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        owner_reg     <= pick_next;
                        burst_cnt_reg <= '0;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_valid) begin
                        // Owner went quiet: release without a transfer.
                        state_reg      <= IDLE;
                        last_owner_reg <= owner_reg;
                    end else if (!fifo_full) begin
                        burst_cnt_reg <= burst_cnt_reg + 5'd1;
                        if (burst_cnt_reg == BURST_LAST) begin
                            state_reg      <= IDLE;
                            last_owner_reg <= owner_reg;
                        end
                    end
                    // fifo_full with a valid owner: hold everything.
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH, 32, data word width in bits.
  NREQ, 4, number of requesters; legal range 2..8.
  BURST, 4, maximum words per grant; legal range 1..16.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  req_valid  in  NREQ  bit k = requester k offers a word.
  req_data  in  NREQ*WIDTH  requester k word at bits [k*WIDTH +: WIDTH].
  req_ready  out  NREQ  bit k = requester k word accepted this cycle.
  fifo_full  in  1  downstream FIFO full flag.
  fifo_w_valid  out  1  write strobe to the FIFO.
  fifo_data_in  out  WIDTH  write data to the FIFO.
  grant_active  out  1  a requester currently holds the grant.
  grant_id  out  3  index of the grant owner; meaningful only when grant_active=1.
  wr_count  out  16  total words written to the FIFO.
REQ-003 The block SHALL have one clock domain, clk. Reset SHALL be asynchronous and active-high, on port reset.

Function
REQ-004 A transfer from requester k SHALL occur on a rising clk edge where req_valid[k]=1 and req_ready[k]=1.
REQ-005 req_ready[k] SHALL be combinational and equal to (state==GRANT && owner==k && !fifo_full).
REQ-006 fifo_w_valid SHALL be req_valid[owner] & req_ready[owner].
REQ-007 fifo_data_in SHALL be req_data[owner], combinational, so the FIFO write happens on the same edge with zero latency.
REQ-008 The FSM SHALL have two states, IDLE and GRANT. grant_active SHALL be 1 exactly in GRANT, and grant_id SHALL equal owner.
REQ-009 IDLE, when any req_valid bit is 1:
  - select the first valid requester in round-robin order starting at (last_owner+1) mod NREQ;
  - register it as owner, clear burst_cnt, go to GRANT.
  - No transfer occurs in the IDLE cycle (one-cycle arbitration bubble).
REQ-010 In GRANT, each transfer SHALL increment burst_cnt.
REQ-011 GRANT SHALL return to IDLE after the transfer made with burst_cnt==BURST-1.
REQ-012 GRANT SHALL return to IDLE in any cycle where req_valid[owner]=0; no transfer occurs in that cycle.
REQ-013 On every GRANT->IDLE transition, last_owner SHALL be loaded with owner.
REQ-014 fifo_full=1 in GRANT:
  - stall with no transfer;
  - grant, owner and burst_cnt held;
  - no timeout;
  - resume on the first cycle fifo_full=0.
REQ-015 Requests other than the owner's SHALL be ignored during GRANT; req_ready for non-owners SHALL stay 0.
REQ-016 If the only valid requester is the previous owner, it SHALL be re-granted after the IDLE bubble.
REQ-017 wr_count SHALL increment by 1 on every fifo_w_valid=1 edge and wrap from 0xFFFF to 0x0000.
REQ-018 No word SHALL be duplicated or dropped.
REQ-019 fifo_w_valid SHALL never be 1 while fifo_full=1.

Reset
REQ-020 Asserting reset SHALL immediately, and asynchronously:
  - force state=IDLE, owner=0, burst_cnt=0, last_owner=NREQ-1, wr_count=0;
  - drive req_ready=0, fifo_w_valid=0, grant_active=0, grant_id=0.
REQ-021 Reset asserted mid-burst SHALL abort the burst with no partial write.
REQ-022 After reset release, the first grant SHALL go to the lowest-index valid requester.

Verification
REQ-023 NREQ=4, BURST=2, all req_valid=1, fifo_full=0 -> grants 0,1,2,3,0. Each grant is 1 bubble plus 2 writes. wr_count=8 after the fourth grant ends.
REQ-024 BURST=4, only requester 2 valid with 5 words -> 4 writes, 1 bubble, re-grant to 2, 1 write, then IDLE. wr_count=5 and data order preserved.
REQ-025 fifo_full=1 for 3 cycles after the first word of a grant to requester 1:
  - req_ready=0, fifo_w_valid=0, grant_id=1 held throughout;
  - the remaining 3 words are written after full drops;
  - no loss or duplication.
REQ-026 Owner 0 drops req_valid after 1 word while requester 1 is valid -> IDLE next cycle, then grant to 1.
REQ-027 reset pulsed mid-burst of requester 3 -> all outputs 0 with no clock edge required, wr_count=0. After release with all valid, first grant goes to 0.
REQ-028 Requester 0 alone streaming 65536 words -> wr_count returns to 0x0000 and keeps counting.
